// File: rtl/argmax_frame_collector.sv
// argmax_frame_collector
// Gathers NUM_INPUTS serial valid/ready samples into one parallel frame for the
// argmax comparator. The frame is held until the consumer takes it; the first
// sample of the next frame may be taken in the same cycle as the hand-off.
//
// Optional feature: define ARGMAX_FRAME_COLLECTOR_LAST_EN to add in_last, which
// closes a frame early. Unfilled entries stay 0 and frm_len reports the count.
//
// state | meaning
// FILL  | accepting samples into entry[wr_idx], no frame presented
// FULL  | frame presented on frm_*, input only moves on a simultaneous hand-off

module argmax_frame_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUTS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
`ifdef ARGMAX_FRAME_COLLECTOR_LAST_EN
    input  logic                  in_last,
`endif
    output logic                  frm_valid,
    input  logic                  frm_ready,
    output logic [DATA_WIDTH-1:0] frm_data [NUM_INPUTS],
    output logic [$clog2(NUM_INPUTS):0] frm_len
);

    localparam int IW = $clog2(NUM_INPUTS);
    localparam int LW = IW + 1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     wr_idx;
    logic              in_acc;
    logic              frm_acc;
    logic              frame_close;
    logic              handoff_last;

    // A beat closes the frame on the last slot, or early when tagged last.
`ifdef ARGMAX_FRAME_COLLECTOR_LAST_EN
    assign frame_close  = (wr_idx == IW'(NUM_INPUTS - 1)) || in_last;
    assign handoff_last = in_last;
`else
    assign frame_close  = (wr_idx == IW'(NUM_INPUTS - 1));
    assign handoff_last = 1'b0;
`endif

    // State register; reset drops frm_valid immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs. in_ready is forced low during reset.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        frm_valid = 1'b0;
        in_acc    = 1'b0;
        frm_acc   = 1'b0;
        case (state)
            FILL: begin
                in_ready = rst_n;
                in_acc   = in_valid && rst_n;
                if (in_acc && frame_close) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                frm_valid = 1'b1;
                in_ready  = frm_ready && rst_n;
                frm_acc   = frm_ready;
                in_acc    = in_valid && frm_ready && rst_n;
                if (frm_acc) begin
                    // A single-sample frame tagged last goes straight back out.
                    state_nxt = (in_acc && handoff_last) ? FULL : FILL;
                end
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // Frame storage, write index and length. Entries not yet written are 0 so
    // they never win an unsigned compare against a real sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx  <= '0;
            frm_len <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                frm_data[i] <= '0;
            end
        end else if (state == FILL) begin
            if (in_acc) begin
                frm_data[wr_idx] <= in_data;
                if (frame_close) begin
                    wr_idx  <= '0;
                    frm_len <= LW'(wr_idx) + LW'(1);
                end else begin
                    wr_idx <= wr_idx + IW'(1);
                end
            end
        end else if (frm_acc) begin
            for (int i = 1; i < NUM_INPUTS; i++) begin
                frm_data[i] <= '0;
            end
            frm_len <= '0;
            if (in_acc) begin
                frm_data[0] <= in_data;
                if (handoff_last) begin
                    wr_idx  <= '0;
                    frm_len <= LW'(1);
                end else begin
                    wr_idx <= IW'(1);
                end
            end else begin
                frm_data[0] <= '0;
                wr_idx      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_argmax_frame_collector.sv
// Directed bench for argmax_frame_collector (default 16 x 16 build). Expected
// frames are hand-computed sequences or drawn from a queue of accepted samples.

module tb_argmax_frame_collector;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        frm_valid;
    logic        frm_ready;
    logic [15:0] frm_data [16];
    logic [4:0]  frm_len;

    int n_checks = 0;
    int n_pass   = 0;

    argmax_frame_collector #(
        .DATA_WIDTH(16),
        .NUM_INPUTS(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
`ifdef ARGMAX_FRAME_COLLECTOR_LAST_EN
        .in_last  (in_last),
`endif
        .frm_valid(frm_valid),
        .frm_ready(frm_ready),
        .frm_data (frm_data),
        .frm_len  (frm_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic last);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        #1;
        while (!in_ready && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) check("send_timeout", 32'(in_ready), 32'd1);
        else          step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_seq(input string tag, input int base);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s[%0d]", tag, i), 32'(frm_data[i]), 32'(16'(base + i)));
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s[%0d]", tag, i), 32'(frm_data[i]), 32'd0);
    endtask

    task automatic accept_frame();
        frm_ready = 1'b1;
        step();
        frm_ready = 1'b0;
    endtask

    logic [15:0] q [$];
    logic [15:0] exp_v;
    int  cnt, valid_cycles, frames_done, cyc;
    logic acc_in, acc_frm;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        frm_ready = 1'b0;

        // Reset state
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_frm_valid", 32'(frm_valid), 32'd0);
        check("rst_frm_len", 32'(frm_len), 32'd0);
        check_zero("rst_entry");
        #20 rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Reset mid-frame after 5 beats, then a clean 1..16 frame
        for (int i = 0; i < 5; i++) send_beat(16'(16'h50 + i), 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check_zero("midrst_entry");
        #10 rst_n = 1'b1;
        step();
        for (int i = 1; i <= 16; i++) begin
            send_beat(16'(i), 1'b0);
            if (i == 15) check("fill_no_valid", 32'(frm_valid), 32'd0);
        end
        check("latency_valid", 32'(frm_valid), 32'd1);
        check("rst_frame_len", 32'(frm_len), 32'd16);
        check_seq("rst_frame", 1);
        accept_frame();
        check("rst_frame_accepted", 32'(frm_valid), 32'd0);

        // Backpressure: frame held, no beat consumed
        for (int i = 0; i < 16; i++) send_beat(16'(100 + i), 1'b0);
        check("bp_valid", 32'(frm_valid), 32'd1);
        in_valid = 1'b1;
        in_data  = 16'd200;
        for (int c = 0; c < 10; c++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            step();
            check("bp_hold_valid", 32'(frm_valid), 32'd1);
            check("bp_hold_e0", 32'(frm_data[0]), 32'd100);
            check("bp_hold_e15", 32'(frm_data[15]), 32'd115);
            check("bp_hold_len", 32'(frm_len), 32'd16);
        end
        in_valid = 1'b0;
        accept_frame();
        check("bp_accept_1cyc", 32'(frm_valid), 32'd0);
        check("bp_len_cleared", 32'(frm_len), 32'd0);
        check_zero("bp_clear");

        // Back-to-back throughput
        cnt = 0;
        valid_cycles = 0;
        frm_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 1; c <= 48; c++) begin
            in_data = cnt[15:0];
            #1;
            if (in_valid && in_ready) cnt++;
            @(posedge clk);
            #1;
            if (frm_valid) begin
                valid_cycles++;
                check("b2b_cycle", 32'(c), 32'(16 * valid_cycles));
                check_seq("b2b_frame", 16 * (valid_cycles - 1));
            end
        end
        check("b2b_count", 32'(valid_cycles), 32'd3);
        in_valid = 1'b0;
        step();
        frm_ready = 1'b0;
        check("b2b_drained", 32'(frm_valid), 32'd0);

        // Hand-off overlap with 0xBEEF
        for (int i = 0; i < 16; i++) send_beat(16'(16'h10 + i), 1'b0);
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        frm_ready = 1'b1;
        #1;
        check("ho_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid  = 1'b0;
        frm_ready = 1'b0;
        check("ho_valid_low", 32'(frm_valid), 32'd0);
        check("ho_e0_early", 32'(frm_data[0]), 32'hBEEF);
        check("ho_e1_zero", 32'(frm_data[1]), 32'd0);
        for (int i = 1; i < 16; i++) send_beat(16'(16'h2000 + i), 1'b0);
        check("ho_valid", 32'(frm_valid), 32'd1);
        check("ho_e0", 32'(frm_data[0]), 32'hBEEF);
        for (int i = 1; i < 16; i++)
            check($sformatf("ho_e[%0d]", i), 32'(frm_data[i]), 32'(16'(16'h2000 + i)));
        accept_frame();

        // Random throttling against a queue of accepted samples
        frames_done = 0;
        cyc = 0;
        in_valid = 1'b0;
        while (frames_done < 40 && cyc < 20000) begin
            if (!in_valid && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b1;
                in_data  = 16'($urandom);
            end
            frm_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc_in  = in_valid && in_ready;
            acc_frm = frm_valid && frm_ready;
            if (acc_frm) begin
                check("rnd_qsize", 32'(q.size() >= 16), 32'd1);
                check("rnd_len", 32'(frm_len), 32'd16);
                for (int i = 0; i < 16; i++) begin
                    exp_v = (q.size() > 0) ? q.pop_front() : 16'hDEAD;
                    check($sformatf("rnd_f%0d[%0d]", frames_done, i), 32'(frm_data[i]), 32'(exp_v));
                end
                frames_done++;
            end
            if (acc_in) q.push_back(in_data);
            step();
            cyc++;
            if (acc_in) in_valid = 1'b0;
        end
        check("rnd_frames", 32'(frames_done), 32'd40);
        in_valid  = 1'b0;
        frm_ready = 1'b0;
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        step();

`ifdef ARGMAX_FRAME_COLLECTOR_LAST_EN
        // Early close with in_last
        send_beat(16'd7, 1'b0);
        send_beat(16'd3, 1'b0);
        send_beat(16'd9, 1'b1);
        check("last_valid", 32'(frm_valid), 32'd1);
        check("last_len", 32'(frm_len), 32'd3);
        check("last_e0", 32'(frm_data[0]), 32'd7);
        check("last_e1", 32'(frm_data[1]), 32'd3);
        check("last_e2", 32'(frm_data[2]), 32'd9);
        for (int i = 3; i < 16; i++)
            check($sformatf("last_e[%0d]", i), 32'(frm_data[i]), 32'd0);
        accept_frame();
        for (int i = 0; i < 16; i++) send_beat(16'(16'h300 + i), 1'b0);
        check("last_next_len", 32'(frm_len), 32'd16);
        check_seq("last_next", 16'h300);
        accept_frame();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
